mac_argmax: RTL and testbench

Downstream stage of `mac3`: it consumes the stream of 20-bit partial sums that `mac3` produces, one per 128-bit pixel/weight word pair. It accumulates WORDS_PER_CLASS consecutive sums into one class score. Over NUM_CLASSES scores it tracks the running maximum, then presents the winning digit index and its score through a valid/ready output. One frame is NUM_CLASSES × WORDS_PER_CLASS input beats, 40 with the defaults.

---
 rtl/digit_pkg.sv | 14 +
 rtl/score_compare.sv | 20 ++
 rtl/mac_argmax.sv | 109 ++++++++++
 tb/tb_mac_argmax.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared constants and FSM encoding for the digit classifier datapath
// (mac3 partial sums feeding mac_argmax).
package digit_pkg;
    localparam int SUM_W           = 20;
    localparam int WORDS_PER_CLASS = 4;
    localparam int NUM_CLASSES     = 10;
    localparam int ACC_W           = 24;
    localparam int CLASS_W         = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;
endpackage

// File: rtl/score_compare.sv
// Running-maximum update for one class score: strict signed greater-than,
// so ties keep the earlier (lower) class index.
module score_compare #(
    parameter int ACC_W   = digit_pkg::ACC_W,
    parameter int CLASS_W = digit_pkg::CLASS_W
) (
    input  logic signed [ACC_W-1:0]   score,
    input  logic signed [ACC_W-1:0]   best_score,
    input  logic        [CLASS_W-1:0] best_idx,
    input  logic        [CLASS_W-1:0] class_cnt,
    input  logic                      first,
    output logic signed [ACC_W-1:0]   best_score_nxt,
    output logic        [CLASS_W-1:0] best_idx_nxt
);
    logic take;

    assign take           = first || (score > best_score);
    assign best_score_nxt = take ? score : best_score;
    assign best_idx_nxt   = take ? class_cnt : best_idx;
endmodule

// File: rtl/mac_argmax.sv
// Accumulates WORDS_PER_CLASS mac3 sums per class score, tracks the argmax
// over NUM_CLASSES scores and presents the winner on a valid/ready port.
module mac_argmax #(
    parameter int SUM_W           = digit_pkg::SUM_W,
    parameter int WORDS_PER_CLASS = digit_pkg::WORDS_PER_CLASS,
    parameter int NUM_CLASSES     = digit_pkg::NUM_CLASSES,
    parameter int ACC_W           = digit_pkg::ACC_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [SUM_W-1:0]             in_sum,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic        [digit_pkg::CLASS_W-1:0] out_class,
    output logic signed [ACC_W-1:0]             out_score
);
    import digit_pkg::*;

    localparam int WCW = (WORDS_PER_CLASS > 1) ? $clog2(WORDS_PER_CLASS) : 1;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [SUM_W-1:0] v);
        return {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
    endfunction

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]   acc;
    logic        [WCW-1:0]     word_cnt;
    logic        [CLASS_W-1:0] class_cnt;
    logic signed [ACC_W-1:0]   best_score;
    logic        [CLASS_W-1:0] best_idx;

    logic                      accept;
    logic                      last_word;
    logic                      last_class;
    logic signed [ACC_W-1:0]   score;
    logic signed [ACC_W-1:0]   best_score_nxt;
    logic        [CLASS_W-1:0] best_idx_nxt;

    assign in_ready   = (state == ST_ACC);
    assign out_valid  = (state == ST_DONE);
    assign accept     = in_valid && in_ready;
    assign last_word  = (word_cnt == WCW'(WORDS_PER_CLASS - 1));
    assign last_class = (class_cnt == CLASS_W'(NUM_CLASSES - 1));
    assign score      = acc + sext(in_sum);

    score_compare #(
        .ACC_W   (ACC_W),
        .CLASS_W (CLASS_W)
    ) u_cmp (
        .score          (score),
        .best_score     (best_score),
        .best_idx       (best_idx),
        .class_cnt      (class_cnt),
        .first          (class_cnt == '0),
        .best_score_nxt (best_score_nxt),
        .best_idx_nxt   (best_idx_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (accept && last_word && last_class) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // Accumulate / compare stage: one accepted beat per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            word_cnt   <= '0;
            class_cnt  <= '0;
            best_score <= '0;
            best_idx   <= '0;
            out_class  <= '0;
            out_score  <= '0;
        end else if (accept) begin
            if (last_word) begin
                acc        <= '0;
                word_cnt   <= '0;
                best_score <= best_score_nxt;
                best_idx   <= best_idx_nxt;
                if (last_class) begin
                    class_cnt <= '0;
                    out_class <= best_idx_nxt;
                    out_score <= best_score_nxt;
                end else begin
                    class_cnt <= class_cnt + 1'b1;
                end
            end else begin
                acc      <= score;
                word_cnt <= word_cnt + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            // Result taken: the next frame starts with a clean running maximum
            best_score <= '0;
            best_idx   <= '0;
        end
    end
endmodule

// File: tb/tb_mac_argmax.sv
// Randomized and directed frames for mac_argmax, checked against a
// per-class sum / argmax reference model.
module tb_mac_argmax;
    localparam int SUM_W = 20;
    localparam int WPC   = 4;
    localparam int NCL   = 10;
    localparam int ACC_W = 24;
    localparam int NBEAT = WPC * NCL;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [SUM_W-1:0] in_sum = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [3:0]              out_class;
    logic signed [ACC_W-1:0] out_score;

    int n_tests = 0;
    int n_fail  = 0;
    int frame[NBEAT];

    always #5 clk = ~clk;

    mac_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain per-class sums, first strict maximum wins.
    task automatic model(output int cls, output int best);
        int sc[NCL];
        for (int c = 0; c < NCL; c++) begin
            sc[c] = 0;
            for (int k = 0; k < WPC; k++) sc[c] += frame[c*WPC + k];
        end
        cls = 0;
        for (int c = 1; c < NCL; c++) if (sc[c] > sc[cls]) cls = c;
        best = sc[cls];
    endtask

    function automatic int rnd_sum(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < NBEAT; i++) frame[i] = v;
    endtask

    task automatic fill_winner(input int w);
        for (int i = 0; i < NBEAT; i++) frame[i] = rnd_sum(-1000, 1000);
        for (int k = 0; k < WPC; k++) frame[w*WPC + k] = rnd_sum(5000, 9000);
    endtask

    task automatic fill_random();
        logic [SUM_W-1:0] r;
        for (int i = 0; i < NBEAT; i++) begin
            r = SUM_W'($urandom);
            frame[i] = int'($signed(r));
        end
    endtask

    // Drives one frame; checks latency and result against the model.
    task automatic run_frame(input string tag, input bit stall, input int exp_cls, input int exp_score);
        int i;
        logic [31:0] es;
        i = 0;
        while (i < NBEAT) begin
            if (stall && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_sum   = SUM_W'($urandom);
                tick();
            end else begin
                in_valid = 1'b1;
                in_sum   = frame[i][SUM_W-1:0];
                if (i == 0) check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
                tick();
                i++;
            end
        end
        in_valid = 1'b0;
        es = 32'(exp_score);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_class"}, 32'(out_class), 32'(exp_cls));
        check({tag, "_score"}, 32'(out_score[ACC_W-1:0]), {8'd0, es[ACC_W-1:0]});
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic model_frame(input string tag, input bit stall);
        int c, s;
        model(c, s);
        run_frame(tag, stall, c, s);
        take_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, s;
        logic [3:0]        hold_cls;
        logic [ACC_W-1:0]  hold_score;

        #12 rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_score", 32'(out_score), 32'd0);

        // Reset mid-frame after 17 beats
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_sum   = SUM_W'(rnd_sum(20000, 90000));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        fill_const(1);
        run_frame("after_rst", 1'b0, 0, 4);
        take_result("after_rst");

        // Single winner: class 7
        fill_const(0);
        for (int k = 0; k < WPC; k++) frame[7*WPC + k] = 'h100;
        run_frame("single7", 1'b0, 7, 'h400);
        take_result("single7");

        // All -1
        fill_const(-1);
        run_frame("all_neg1", 1'b0, 0, -4);
        take_result("all_neg1");

        // Tie between classes 3 and 8
        fill_const(-5);
        for (int k = 0; k < WPC; k++) begin
            frame[3*WPC + k] = (k == 3) ? 20 : 10;
            frame[8*WPC + k] = (k == 0) ? 20 : 10;
        end
        run_frame("tie", 1'b0, 3, 50);
        take_result("tie");

        // Sign extremes
        fill_const(-(1 << 19));
        for (int k = 0; k < WPC; k++) frame[2*WPC + k] = (1 << 19) - 1;
        run_frame("extremes", 1'b0, 2, 'h1FFFFC);
        take_result("extremes");

        // Backpressure: hold result while garbage is offered on the input
        fill_winner(1);
        model(c, s);
        run_frame("bp1", 1'b0, c, s);
        hold_cls   = out_class;
        hold_score = out_score;
        for (int t = 0; t < 10; t++) begin
            in_valid = 1'b1;
            in_sum   = SUM_W'($urandom);
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_class", 32'(out_class), 32'(hold_cls));
            check("bp_hold_score", 32'(out_score), 32'(hold_score));
        end
        in_valid = 1'b0;
        take_result("bp1");
        fill_winner(5);
        model(c, s);
        check("bp2_model_winner", 32'(c), 32'd5);
        run_frame("bp2", 1'b0, c, s);
        take_result("bp2");

        // out_ready already high when the result appears: one-cycle pulse
        fill_winner(4);
        model(c, s);
        out_ready = 1'b1;
        run_frame("early_rdy", 1'b0, c, s);
        tick();
        check("early_rdy_pulse", 32'(out_valid), 32'd0);
        check("early_rdy_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Input stalls: same frame unstalled and stalled
        fill_winner(9);
        model_frame("nostall9", 1'b0);
        model_frame("stall9", 1'b1);

        // Random full-range frames, some stalled
        for (int f = 0; f < 6; f++) begin
            fill_random();
            model_frame("rand", f[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
